vram_port: RTL and testbench



---
 rtl/vram_port.sv | 104 ++++++++++
 tb/tb_vram_port.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port.sv
// Video-RAM responder: one single-port word RAM shared between CPU bus accesses
// and VGA pixel fetches, with VGA given fixed priority and one-cycle latency.
module vram_port #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic              wvram,
  input  logic              rvram,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ready,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic              err_starve
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DONE = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  logic [ADDR_W-1:0] cpu_word;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rd_p0;
  logic              cpu_req;
  logic              cpu_grant;
  logic              cpu_wr;
  logic              cpu_rd;
  logic              ram_we;
  logic              unused_addr_bits;

  // Byte-lane and high address bits are don't-care: the window aliases.
  assign cpu_word         = cpu_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

  assign cpu_req   = wvram | rvram;
  assign cpu_grant = (state == IDLE) & cpu_req & ~vga_req;
  assign cpu_wr    = cpu_grant & wvram;
  assign cpu_rd    = cpu_grant & rvram & ~wvram;

  // A reset edge aborts a write that would otherwise commit at that edge.
  assign ram_we    = cpu_wr & clrn;

  assign ram_addr  = vga_req ? vga_addr : cpu_word;
  assign ram_rd_p0 = mem[ram_addr];

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      IDLE: begin
        if (!cpu_req) begin
          wait_next = '0;
        end else if (vga_req) begin
          if (wait_cnt != WAIT_MAX) wait_next = wait_cnt + WAIT_W'(1);
        end else begin
          wait_next  = '0;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= cpu_din;
  end

  // Stage p0 -> p1: RAM read word lands in the client output registers.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      err_starve <= 1'b0;
      vga_valid  <= 1'b0;
      vga_data   <= '0;
      cpu_dout   <= '0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_next;
      err_starve <= err_starve | (wait_next == WAIT_MAX);
      vga_valid  <= vga_req;
      if (vga_req) vga_data <= ram_rd_p0;
      if (cpu_rd)  cpu_dout <= ram_rd_p0;
    end
  end

  assign cpu_ready = (state == DONE);

endmodule

// File: tb/tb_vram_port.sv
// Directed bench for vram_port: CPU/VGA arbitration, latency, starvation flag,
// aliasing, dual-strobe writes and reset during an access.
module tb_vram_port;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              clrn;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic              wvram;
  logic              rvram;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_ready;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  logic              err_starve;

  int n_checks = 0;
  int n_fail   = 0;

  vram_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(15)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .wvram      (wvram),
    .rvram      (rvram),
    .cpu_dout   (cpu_dout),
    .cpu_ready  (cpu_ready),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_data   (vga_data),
    .vga_valid  (vga_valid),
    .err_starve (err_starve)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // CPU write through the normal handshake; ends in the IDLE cycle after DONE.
  task automatic cpu_write(input string tag, input logic [31:0] addr,
                           input logic [DATA_W-1:0] data);
    int n;
    cpu_addr = addr;
    cpu_din  = data;
    wvram    = 1'b1;
    step();
    n = 0;
    while (cpu_ready !== 1'b1 && n < 32) begin
      step();
      n++;
    end
    check(tag, {31'd0, cpu_ready}, 32'd1);
    wvram = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn     = 1'b0;
    cpu_addr = '0;
    cpu_din  = '0;
    wvram    = 1'b0;
    rvram    = 1'b0;
    vga_req  = 1'b0;
    vga_addr = '0;
    step();
    step();

    check("rst_cpu_ready",  {31'd0, cpu_ready},  32'd0);
    check("rst_vga_valid",  {31'd0, vga_valid},  32'd0);
    check("rst_err_starve", {31'd0, err_starve}, 32'd0);
    check("rst_cpu_dout",   cpu_dout, 32'd0);
    check("rst_vga_data",   vga_data, 32'd0);
    clrn = 1'b1;
    step();

    // Write then read back, minimum latency
    cpu_addr = 32'hC000_0010;
    cpu_din  = 32'hDEAD_BEEF;
    wvram    = 1'b1;
    step();
    check("wr_ready_n1", {31'd0, cpu_ready}, 32'd1);
    wvram = 1'b0;
    step();
    check("wr_ready_pulse", {31'd0, cpu_ready}, 32'd0);
    rvram = 1'b1;
    step();
    check("rd_ready_n1", {31'd0, cpu_ready}, 32'd1);
    check("rd_data", cpu_dout, 32'hDEAD_BEEF);
    rvram = 1'b0;
    step();

    // VGA streaming fetch of three words
    cpu_write("w0_ready", 32'hC000_0000, 32'h0000_0011);
    cpu_write("w1_ready", 32'hC000_0004, 32'h0000_0022);
    cpu_write("w2_ready", 32'hC000_0008, 32'h0000_0033);
    vga_req  = 1'b1;
    vga_addr = 13'd0;
    step();
    check("vga0_valid", {31'd0, vga_valid}, 32'd1);
    check("vga0_data", vga_data, 32'h0000_0011);
    vga_addr = 13'd1;
    step();
    check("vga1_valid", {31'd0, vga_valid}, 32'd1);
    check("vga1_data", vga_data, 32'h0000_0022);
    vga_addr = 13'd2;
    step();
    check("vga2_valid", {31'd0, vga_valid}, 32'd1);
    check("vga2_data", vga_data, 32'h0000_0033);
    vga_req = 1'b0;
    step();
    check("vga_idle_valid", {31'd0, vga_valid}, 32'd0);

    // CPU read blocked by five VGA cycles
    cpu_addr = 32'hC000_0004;
    rvram    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vga_req  = 1'b1;
      vga_addr = 13'(i);
      step();
      check("blk_cpu_ready", {31'd0, cpu_ready}, 32'd0);
      check("blk_vga_valid", {31'd0, vga_valid}, 32'd1);
    end
    vga_req = 1'b0;
    check("blk_drop_ready", {31'd0, cpu_ready}, 32'd0);
    step();
    check("blk_grant_ready", {31'd0, cpu_ready}, 32'd1);
    check("blk_grant_data", cpu_dout, 32'h0000_0022);
    check("blk_no_starve", {31'd0, err_starve}, 32'd0);
    rvram = 1'b0;
    step();

    // Starvation: pending write held off by 20 VGA cycles
    cpu_write("w8_ready", 32'hC000_0020, 32'hCAFE_F00D);
    cpu_addr = 32'hC000_0020;
    cpu_din  = 32'h1234_5678;
    wvram    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vga_req  = 1'b1;
      vga_addr = 13'd8;
      step();
      check("stv_ram_unchanged", vga_data, 32'hCAFE_F00D);
      check("stv_err_starve", {31'd0, err_starve}, (i >= 14) ? 32'd1 : 32'd0);
    end
    vga_req = 1'b0;
    check("stv_denied_ready", {31'd0, cpu_ready}, 32'd0);
    step();
    check("stv_grant_ready", {31'd0, cpu_ready}, 32'd1);
    check("stv_sticky", {31'd0, err_starve}, 32'd1);
    wvram    = 1'b0;
    vga_req  = 1'b1;
    vga_addr = 13'd8;
    step();
    check("stv_committed", vga_data, 32'h1234_5678);
    vga_req = 1'b0;
    step();

    // Both strobes: write to aliased word 2, cpu_dout untouched
    cpu_addr = 32'hC000_8008;
    cpu_din  = 32'hA5A5_A5A5;
    wvram    = 1'b1;
    rvram    = 1'b1;
    step();
    check("both_ready", {31'd0, cpu_ready}, 32'd1);
    check("both_dout_kept", cpu_dout, 32'h0000_0022);
    wvram = 1'b0;
    rvram = 1'b0;
    step();
    check("both_dout_idle", cpu_dout, 32'h0000_0022);
    vga_req  = 1'b1;
    vga_addr = 13'd2;
    step();
    check("both_alias_word2", vga_data, 32'hA5A5_A5A5);
    vga_req = 1'b0;
    step();

    // Reset during the DONE cycle of a write
    cpu_addr = 32'hC000_0030;
    cpu_din  = 32'h0000_0055;
    wvram    = 1'b1;
    step();
    check("rstw_ready", {31'd0, cpu_ready}, 32'd1);
    wvram    = 1'b0;
    clrn     = 1'b0;
    vga_req  = 1'b1;
    vga_addr = 13'd2;
    step();
    check("rstw_cpu_ready",  {31'd0, cpu_ready},  32'd0);
    check("rstw_vga_valid",  {31'd0, vga_valid},  32'd0);
    check("rstw_err_starve", {31'd0, err_starve}, 32'd0);
    check("rstw_cpu_dout",   cpu_dout, 32'd0);
    check("rstw_vga_data",   vga_data, 32'd0);
    clrn     = 1'b1;
    vga_addr = 13'd12;
    step();
    check("rstw_kept_valid", {31'd0, vga_valid}, 32'd1);
    check("rstw_kept_data", vga_data, 32'h0000_0055);
    vga_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
